// File: rtl/spi_minion_valrdy.sv
// spi_minion_valrdy: SPI mode-0 minion, full-duplex nbits-bit transfers with val/rdy parallel sides.
// Optional macro SPI_MINION_DROP_CNT_EN adds an 8-bit saturating count of discarded rx words.
`default_nettype none

module spi_minion_valrdy #(
  parameter int nbits = 34,
  parameter int cntw  = $clog2(nbits) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  input  logic             tx_val,
  output logic             tx_rdy,
  input  logic [nbits-1:0] tx_msg,
  output logic             rx_val,
  input  logic             rx_rdy,
  output logic [nbits-1:0] rx_msg,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clr
`ifdef SPI_MINION_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2,
    COMMIT    = 2'd3
  } state_t;

  localparam logic [cntw-1:0] bits_full = cntw'(nbits);

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cs_sr;
  logic [2:0]        sclk_sr;
  logic [1:0]        mosi_sr;
  logic [1:0]        settle;
  logic              cs_sync;
  logic              mosi_sync;
  logic              cs_fall;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              start;
  logic              commit_load;
  logic              commit_ovf;
  logic              commit_short;
  logic              shift_in;
  logic              shift_out;
  logic              tx_xfer;
  logic              tx_full;
  logic [nbits-1:0]  tx_buf;
  logic [nbits-1:0]  tx_shift;
  logic [nbits-1:0]  rx_shift;
  logic [cntw-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sr   <= 3'b111;
      sclk_sr <= 3'b000;
      mosi_sr <= 2'b00;
    end else begin
      cs_sr   <= {cs_sr[1:0], spi_cs};
      sclk_sr <= {sclk_sr[1:0], spi_sclk};
      mosi_sr <= {mosi_sr[0], spi_mosi};
    end
  end

  assign cs_sync   = cs_sr[1];
  assign mosi_sync = mosi_sr[1];
  assign cs_fall   = cs_sr[2] & ~cs_sr[1];
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = sclk_sr[2] & ~sclk_sr[1];

  // The cs stages reset high, so cs_sync is not trustworthy until the
  // pipeline has refilled from the pin; this keeps a CS already low at
  // reset release from being mistaken for a fresh high-then-fall.
  always_ff @(posedge clk) begin
    if (reset)              settle <= 2'd0;
    else if (settle != 2'd3) settle <= settle + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_HIGH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    commit_load  = 1'b0;
    commit_ovf   = 1'b0;
    commit_short = 1'b0;
    case (state)
      WAIT_HIGH: if (settle == 2'd3 && cs_sync) state_nxt = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
        end
      end
      ACTIVE: if (cs_sync) state_nxt = COMMIT;
      COMMIT: begin
        state_nxt = IDLE;
        if (cnt == bits_full) begin
          if (!rx_val || rx_rdy) commit_load = 1'b1;
          else                   commit_ovf  = 1'b1;
        end else begin
          commit_short = 1'b1;
        end
      end
      default: state_nxt = WAIT_HIGH;
    endcase
  end

  assign shift_in  = (state == ACTIVE) && sclk_rise;
  assign shift_out = (state == ACTIVE) && sclk_fall;
  assign tx_rdy    = ~tx_full;
  assign tx_xfer   = tx_val & ~tx_full;
  assign spi_miso  = (state == ACTIVE) && tx_shift[nbits-1];

  // A word accepted in the cs_fall cycle lands in the buffer for the next
  // transaction; the shift register takes the pre-edge buffer contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (tx_xfer) begin
      tx_buf  <= tx_msg;
      tx_full <= 1'b1;
    end else if (start) begin
      tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          tx_shift <= '0;
    else if (start)     tx_shift <= tx_full ? tx_buf : '0;
    else if (shift_out) tx_shift <= {tx_shift[nbits-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift <= '0;
      cnt      <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (shift_in) begin
      rx_shift <= {rx_shift[nbits-2:0], mosi_sync};
      if (cnt != bits_full) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_msg <= '0;
      rx_val <= 1'b0;
    end else if (commit_load) begin
      rx_msg <= rx_shift;
      rx_val <= 1'b1;
    end else if (rx_val && rx_rdy) begin
      rx_val <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (commit_ovf)            err_ovf <= 1'b1;
      else if (err_clr)          err_ovf <= 1'b0;
      if (start && !tx_full)     err_unf <= 1'b1;
      else if (err_clr)          err_unf <= 1'b0;
    end
  end

`ifdef SPI_MINION_DROP_CNT_EN
  logic drop_evt;
  assign drop_evt = commit_ovf | commit_short;

  always_ff @(posedge clk) begin
    if (reset)                             drop_cnt <= 8'd0;
    else if (err_clr)                      drop_cnt <= drop_evt ? 8'd1 : 8'd0;
    else if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  logic unused_short;
  assign unused_short = commit_short;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_minion_valrdy.sv
// Scoreboard bench for spi_minion_valrdy: directed SPI transactions, queued expectations.
`default_nettype none

module tb_spi_minion_valrdy;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs, spi_sclk, spi_mosi, spi_miso;
  logic        tx_val, tx_rdy, rx_val, rx_rdy;
  logic [33:0] tx_msg, rx_msg;
  logic        err_ovf, err_unf, err_clr;
`ifdef SPI_MINION_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [33:0] rx_exp_q[$];
  logic [33:0] miso_exp_q[$];
  logic [33:0] miso_got_q[$];

  always #5 clk = ~clk;

  spi_minion_valrdy dut (
    .clk      (clk),
    .reset    (reset),
    .spi_cs   (spi_cs),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .tx_val   (tx_val),
    .tx_rdy   (tx_rdy),
    .tx_msg   (tx_msg),
    .rx_val   (rx_val),
    .rx_rdy   (rx_rdy),
    .rx_msg   (rx_msg),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf),
    .err_clr  (err_clr)
`ifdef SPI_MINION_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // rx side: every accepted handshake must match the oldest expected word.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rx_val === 1'b1 && rx_rdy === 1'b1) begin
        if (rx_exp_q.size() == 0) check("rx_unexpected", rx_msg, 34'h0);
        else begin
          e = rx_exp_q.pop_front();
          check("rx_msg", rx_msg, e);
        end
      end
    end
  end

  // MISO side: words captured by the master are matched against expectations.
  initial begin
    logic [33:0] g;
    forever begin
      @(negedge clk);
      #1;
      if (miso_got_q.size() != 0) begin
        g = miso_got_q.pop_front();
        if (miso_exp_q.size() == 0) check("miso_unexpected", g, 34'h0);
        else check("miso_word", g, miso_exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic spi_xfer(input logic [33:0] word, input int nb, input int rst_at, input bit chk);
    logic [33:0] cap;
    cap = '0;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
      spi_mosi = word[33-i];
      repeat (4) @(negedge clk);
      cap = {cap[32:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    repeat (10) @(negedge clk);
    if (chk) miso_got_q.push_back(cap);
  endtask

  task automatic load_tx(input logic [33:0] w);
    @(negedge clk);
    tx_msg = w;
    tx_val = 1'b1;
    @(negedge clk);
    tx_val = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    tx_val = 1'b0; tx_msg = '0; rx_rdy = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_miso", spi_miso, 0);
    check("rst_tx_rdy", tx_rdy, 1);
    check("rst_rx_val", rx_val, 0);
    check("rst_rx_msg", rx_msg, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_unf", err_unf, 0);
    repeat (5) @(negedge clk);

    // Full-duplex round trip
    load_tx(34'h2_AAAA_5555);
    check("rt_tx_full", tx_rdy, 0);
    miso_exp_q.push_back(34'h2_AAAA_5555);
    rx_exp_q.push_back(34'h1_2345_6789);
    fork
      spi_xfer(34'h1_2345_6789, 34, -1, 1'b1);
      begin
        @(negedge spi_cs);
        repeat (4) @(negedge clk);
        check("rt_tx_rdy_after_fall", tx_rdy, 1);
      end
    join
    check("rt_err_unf", err_unf, 0);

    // Underflow
    miso_exp_q.push_back(34'h0);
    rx_exp_q.push_back(34'h3_0F0F_1234);
    spi_xfer(34'h3_0F0F_1234, 34, -1, 1'b1);
    check("unf_set", err_unf, 1);
    check("unf_no_ovf", err_ovf, 0);
    pulse_clr();
    check("unf_cleared", err_unf, 0);

    // Overflow
    rx_rdy = 1'b0;
    load_tx(34'h1_1111_1111);
    miso_exp_q.push_back(34'h1_1111_1111);
    rx_exp_q.push_back(34'h0_0000_0ABC);
    spi_xfer(34'h0_0000_0ABC, 34, -1, 1'b1);
    load_tx(34'h2_2222_2222);
    miso_exp_q.push_back(34'h2_2222_2222);
    spi_xfer(34'h3_FFFF_0000, 34, -1, 1'b1);
    check("ovf_set", err_ovf, 1);
    check("ovf_held_val", rx_val, 1);
    check("ovf_held_msg", rx_msg, 34'h0_0000_0ABC);
`ifdef SPI_MINION_DROP_CNT_EN
    check("ovf_drop_cnt", drop_cnt, 1);
`endif
    rx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    pulse_clr();
    check("ovf_cleared", err_ovf, 0);
`ifdef SPI_MINION_DROP_CNT_EN
    check("drop_cnt_cleared", drop_cnt, 0);
`endif

    // Short packet: 20 bits only
    load_tx(34'h0_DEAD_BEEF);
    miso_exp_q.push_back(34'h0_DEAD_BEEF >> 14);
    spi_xfer(34'h1_5555_5555, 20, -1, 1'b1);
    check("short_rx_val", rx_val, 0);
    check("short_tx_consumed", tx_rdy, 1);
    check("short_err_ovf", err_ovf, 0);
    check("short_err_unf", err_unf, 0);
`ifdef SPI_MINION_DROP_CNT_EN
    check("short_drop_cnt", drop_cnt, 1);
`endif

    // Reset in the middle of a transaction
    load_tx(34'h0_1234_5678);
    spi_xfer(34'h2_7777_7777, 34, 10, 1'b0);
    check("mid_rst_rx_val", rx_val, 0);
    check("mid_rst_rx_msg", rx_msg, 0);
    check("mid_rst_tx_rdy", tx_rdy, 1);
    check("mid_rst_err_unf", err_unf, 0);
    check("mid_rst_err_ovf", err_ovf, 0);
    check("mid_rst_miso", spi_miso, 0);
`ifdef SPI_MINION_DROP_CNT_EN
    check("mid_rst_drop_cnt", drop_cnt, 0);
`endif
    load_tx(34'h3_C3C3_C3C3);
    miso_exp_q.push_back(34'h3_C3C3_C3C3);
    rx_exp_q.push_back(34'h2_4681_3579);
    spi_xfer(34'h2_4681_3579, 34, -1, 1'b1);
    check("post_rst_err_unf", err_unf, 0);

    // Simultaneous consume/commit and tx accepted in the cs_fall cycle
    rx_rdy = 1'b0;
    load_tx(34'h0_0F0F_0F0F);
    miso_exp_q.push_back(34'h0_0F0F_0F0F);
    rx_exp_q.push_back(34'h0_AAAA_0001);
    spi_xfer(34'h0_AAAA_0001, 34, -1, 1'b1);
    check("sim_first_held", rx_val, 1);
    miso_exp_q.push_back(34'h0);
    rx_exp_q.push_back(34'h1_BBBB_0002);
    fork
      spi_xfer(34'h1_BBBB_0002, 34, -1, 1'b1);
      begin
        @(negedge spi_cs);
        repeat (2) @(negedge clk);
        tx_msg = 34'h2_5A5A_A5A5;
        tx_val = 1'b1;
        @(negedge clk);
        tx_val = 1'b0;
        check("sim_tx_held", tx_rdy, 0);
      end
      begin
        @(posedge spi_cs);
        repeat (3) @(negedge clk);
        rx_rdy = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0;
      end
    join
    check("sim_no_ovf", err_ovf, 0);
    check("sim_new_val", rx_val, 1);
    check("sim_new_msg", rx_msg, 34'h1_BBBB_0002);
    check("sim_unf", err_unf, 1);
    rx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    miso_exp_q.push_back(34'h2_5A5A_A5A5);
    rx_exp_q.push_back(34'h3_1357_9BDF);
    spi_xfer(34'h3_1357_9BDF, 34, -1, 1'b1);

    repeat (20) @(negedge clk);
    check("rx_q_drained", 34'(rx_exp_q.size()), 34'h0);
    check("miso_q_drained", 34'(miso_exp_q.size()), 34'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
